// File: rtl/exanet_crosb_pkg.sv
// Shared parameters, types and helpers for the crossbar output-link credit arbiter.
package exanet_crosb_pkg;

  localparam int unsigned PRIO_NUM      = 2;
  localparam int unsigned VC_NUM        = 2;
  localparam int unsigned NQ            = PRIO_NUM * VC_NUM;
  localparam int unsigned INIT_CREDITS  = 40;
  localparam int unsigned MAX_PKT_FLITS = 20;
  localparam int unsigned CRED_W        = $clog2(INIT_CREDITS + 1);
  localparam int unsigned LEN_W         = $clog2(MAX_PKT_FLITS + 1);
  localparam int unsigned LOG_VC_PRIO   = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int unsigned VC_W          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned PRIO_W        = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1;

  typedef enum logic {IDLE, XFER} link_arb_state_t;

  // A whole packet may start only if every flit already has a downstream slot.
  function automatic logic credit_fits(input logic [CRED_W-1:0] credits,
                                       input logic [LEN_W-1:0]  length);
    return 32'(credits) >= 32'(length);
  endfunction

  // Packet lengths must be 1..MAX_PKT_FLITS.
  function automatic logic len_legal(input logic [LEN_W-1:0] length);
    return (length != '0) && (32'(length) <= MAX_PKT_FLITS);
  endfunction

endpackage

// File: rtl/exa_crosb_prio_rr_arb.sv
// Combinational strict-priority pick with a round-robin choice inside each priority.
module exa_crosb_prio_rr_arb
  import exanet_crosb_pkg::*;
(
  input  logic [NQ-1:0]                 eligible,
  input  logic [PRIO_NUM-1:0][VC_W-1:0] rr_ptr,
  output logic [LOG_VC_PRIO-1:0]        winner,
  output logic                          found
);

  int unsigned prio;
  int unsigned slot;

  // Scan priorities high to low; within one, start at its pointer and wrap.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    prio   = 0;
    slot   = 0;
    for (int unsigned p = 0; p < PRIO_NUM; p++) begin
      prio = PRIO_NUM - 1 - p;
      for (int unsigned k = 0; k < VC_NUM; k++) begin
        slot = prio * VC_NUM + (32'(rr_ptr[PRIO_W'(prio)]) + k) % VC_NUM;
        if (!found && eligible[LOG_VC_PRIO'(slot)]) begin
          found  = 1'b1;
          winner = LOG_VC_PRIO'(slot);
        end
      end
    end
  end

endmodule

// File: rtl/exa_crosb_link_credit_arb.sv
// Per-output-port link arbiter: per-VC downstream credits, whole-packet grants,
// flit pass-through to the link transmitter.
module exa_crosb_link_credit_arb
  import exanet_crosb_pkg::*;
(
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NQ-1:0]                i_q_has_packet,
  input  logic [NQ-1:0][LEN_W-1:0]     i_q_pkt_flits,
  output logic [LOG_VC_PRIO-1:0]       o_sel_q,
  output logic                         o_sel_valid,
  input  logic                         i_flit_valid,
  input  logic                         i_flit_last,
  output logic                         o_flit_ready,
  output logic                         o_tx_valid,
  output logic                         o_tx_last,
  input  logic                         i_tx_ready,
  input  logic                         i_cred_ret_valid,
  input  logic [LOG_VC_PRIO-1:0]       i_cred_ret_q,
  input  logic [LEN_W-1:0]             i_cred_ret_cnt,
  output logic [NQ-1:0][CRED_W-1:0]    o_credits,
  output logic                         o_cred_overflow,
  output logic                         o_len_error,
  output logic [31:0]                  o_pkt_sent
);

  link_arb_state_t               state, state_nxt;
  logic [NQ-1:0]                 eligible;
  logic [NQ-1:0]                 len_bad;
  logic [PRIO_NUM-1:0][VC_W-1:0] rr_ptr;
  logic [LOG_VC_PRIO-1:0]        win_q;
  logic                          win_found;
  logic [PRIO_W-1:0]             win_prio;
  logic [VC_W-1:0]               win_vc;
  logic [VC_W-1:0]               win_vc_nxt;
  logic                          grant;
  logic                          beat;
  logic                          pkt_end;
  logic [LEN_W-1:0]              grant_len;
  logic [LEN_W-1:0]              flit_cnt;
  logic [NQ-1:0][CRED_W:0]       cred_sum;

  // Eligibility per queue; an illegal head length never competes.
  always_comb begin
    eligible = '0;
    len_bad  = '0;
    for (int q = 0; q < NQ; q++) begin
      len_bad[q]  = i_q_has_packet[q] & ~len_legal(i_q_pkt_flits[q]);
      eligible[q] = i_q_has_packet[q] & len_legal(i_q_pkt_flits[q])
                  & credit_fits(o_credits[q], i_q_pkt_flits[q]);
    end
  end

  exa_crosb_prio_rr_arb u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (win_q),
    .found    (win_found)
  );

  assign win_prio   = PRIO_W'(32'(win_q) / VC_NUM);
  assign win_vc     = VC_W'(32'(win_q) % VC_NUM);
  assign win_vc_nxt = (win_vc == VC_W'(VC_NUM - 1)) ? '0 : win_vc + 1'b1;

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and flit handshake; no handshake is offered in a reset cycle.
  always_comb begin
    state_nxt    = state;
    grant        = 1'b0;
    beat         = 1'b0;
    pkt_end      = 1'b0;
    o_tx_valid   = 1'b0;
    o_tx_last    = 1'b0;
    o_flit_ready = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant     = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        o_tx_valid   = i_flit_valid & ~ARESET;
        o_tx_last    = i_flit_last;
        o_flit_ready = i_tx_ready & ~ARESET;
        beat         = i_flit_valid & i_tx_ready;
        if (beat && i_flit_last) begin
          pkt_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next credit per queue: grant debit and return merged in one extra-wide sum.
  always_comb begin
    cred_sum = '0;
    for (int q = 0; q < NQ; q++) begin
      cred_sum[q] = {1'b0, o_credits[q]};
      if (grant && (win_q == LOG_VC_PRIO'(q)))
        cred_sum[q] = cred_sum[q] - (CRED_W + 1)'(i_q_pkt_flits[q]);
      if (i_cred_ret_valid && (i_cred_ret_q == LOG_VC_PRIO'(q)))
        cred_sum[q] = cred_sum[q] + (CRED_W + 1)'(i_cred_ret_cnt);
    end
  end

  // Credits, grant bookkeeping, packet counter and sticky errors.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int q = 0; q < NQ; q++) o_credits[q] <= CRED_W'(INIT_CREDITS);
      rr_ptr          <= '0;
      o_sel_q         <= '0;
      o_sel_valid     <= 1'b0;
      grant_len       <= '0;
      flit_cnt        <= '0;
      o_pkt_sent      <= '0;
      o_cred_overflow <= 1'b0;
      o_len_error     <= 1'b0;
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (cred_sum[q] > (CRED_W + 1)'(INIT_CREDITS)) begin
          o_credits[q]    <= CRED_W'(INIT_CREDITS);
          o_cred_overflow <= 1'b1;
        end else begin
          o_credits[q] <= cred_sum[q][CRED_W-1:0];
        end
      end
      if (|len_bad) o_len_error <= 1'b1;
      if (grant) begin
        o_sel_q          <= win_q;
        o_sel_valid      <= 1'b1;
        grant_len        <= i_q_pkt_flits[win_q];
        flit_cnt         <= '0;
        rr_ptr[win_prio] <= win_vc_nxt;
      end
      if (beat) flit_cnt <= flit_cnt + 1'b1;
      if (pkt_end) begin
        o_sel_valid <= 1'b0;
        o_pkt_sent  <= o_pkt_sent + 32'd1;
        if ((flit_cnt + 1'b1) != grant_len) o_len_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exa_crosb_link_credit_arb.sv
// Bench for the link credit arbiter: directed scenarios plus randomized traffic,
// all checked against a packet-level reference model.
module tb_exa_crosb_link_credit_arb;
  import exanet_crosb_pkg::*;

  logic                       ACLK = 1'b0;
  logic                       ARESET = 1'b1;
  logic [NQ-1:0]              i_q_has_packet = '0;
  logic [NQ-1:0][LEN_W-1:0]   i_q_pkt_flits = '0;
  logic [LOG_VC_PRIO-1:0]     o_sel_q;
  logic                       o_sel_valid;
  logic                       i_flit_valid = 1'b0;
  logic                       i_flit_last = 1'b0;
  logic                       o_flit_ready;
  logic                       o_tx_valid;
  logic                       o_tx_last;
  logic                       i_tx_ready = 1'b0;
  logic                       i_cred_ret_valid = 1'b0;
  logic [LOG_VC_PRIO-1:0]     i_cred_ret_q = '0;
  logic [LEN_W-1:0]           i_cred_ret_cnt = '0;
  logic [NQ-1:0][CRED_W-1:0]  o_credits;
  logic                       o_cred_overflow;
  logic                       o_len_error;
  logic [31:0]                o_pkt_sent;

  always #5 ACLK = ~ACLK;

  exa_crosb_link_credit_arb dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .i_q_has_packet   (i_q_has_packet),
    .i_q_pkt_flits    (i_q_pkt_flits),
    .o_sel_q          (o_sel_q),
    .o_sel_valid      (o_sel_valid),
    .i_flit_valid     (i_flit_valid),
    .i_flit_last      (i_flit_last),
    .o_flit_ready     (o_flit_ready),
    .o_tx_valid       (o_tx_valid),
    .o_tx_last        (o_tx_last),
    .i_tx_ready       (i_tx_ready),
    .i_cred_ret_valid (i_cred_ret_valid),
    .i_cred_ret_q     (i_cred_ret_q),
    .i_cred_ret_cnt   (i_cred_ret_cnt),
    .o_credits        (o_credits),
    .o_cred_overflow  (o_cred_overflow),
    .o_len_error      (o_len_error),
    .o_pkt_sent       (o_pkt_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-queue packet lists and credits, link-level view.
  int          pkts[NQ][$];
  int          m_cred[NQ];
  int          m_ptr[PRIO_NUM];
  bit          m_busy;
  int          m_sel_q;
  int          m_len;
  int          m_beats;
  bit          m_ovf;
  bit          m_lerr;
  int unsigned m_sent;

  // Stimulus controls.
  int p_valid    = 100;
  int p_ready    = 100;
  int stall      = 0;
  int early_last = -1;
  bit rst_req    = 1'b1;
  bit ret_rand   = 1'b0;
  bit ret_once   = 1'b0;
  int ret_q_once = 0;
  int ret_cnt_once = 0;

  int dut_log[$];
  bit prev_sel = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_pkts();
    for (int q = 0; q < NQ; q++) if (pkts[q].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit legal_len(input int l);
    return (l >= 1) && (l <= int'(MAX_PKT_FLITS));
  endfunction

  task automatic model_step(input bit v, input bit r, input bit l,
                            input bit rv, input int rq, input int rc);
    int win;
    int c;
    int q;
    if (rst_req) begin
      for (int i = 0; i < NQ; i++) begin
        m_cred[i] = INIT_CREDITS;
        pkts[i].delete();
      end
      for (int p = 0; p < PRIO_NUM; p++) m_ptr[p] = 0;
      m_busy = 0; m_sel_q = 0; m_len = 0; m_beats = 0;
      m_ovf = 0; m_lerr = 0; m_sent = 0;
      return;
    end
    for (int i = 0; i < NQ; i++)
      if (pkts[i].size() > 0 && !legal_len(pkts[i][0])) m_lerr = 1;
    win = -1;
    if (!m_busy) begin
      for (int p = PRIO_NUM - 1; p >= 0 && win < 0; p--)
        for (int k = 0; k < VC_NUM && win < 0; k++) begin
          q = p * VC_NUM + (m_ptr[p] + k) % VC_NUM;
          if (pkts[q].size() > 0 && legal_len(pkts[q][0]) && pkts[q][0] <= m_cred[q]) win = q;
        end
    end
    for (int i = 0; i < NQ; i++) begin
      c = m_cred[i];
      if (i == win) c -= pkts[i][0];
      if (rv && rq == i) c += rc;
      if (c > int'(INIT_CREDITS)) begin c = INIT_CREDITS; m_ovf = 1; end
      m_cred[i] = c;
    end
    if (win >= 0) begin
      m_busy = 1; m_sel_q = win; m_len = pkts[win][0]; m_beats = 0;
      m_ptr[win / VC_NUM] = (win % VC_NUM + 1) % VC_NUM;
    end else if (m_busy && v && r) begin
      m_beats++;
      if (l) begin
        m_sent++;
        if (m_beats != m_len) m_lerr = 1;
        void'(pkts[m_sel_q].pop_front());
        m_busy = 0;
      end
    end
  endtask

  // One clock: drive at negedge, check handshake, advance model, check registers.
  task automatic cycle();
    bit v, r, l, rv;
    int rq, rc, mx;
    @(negedge ACLK);
    ARESET = rst_req;
    for (int q = 0; q < NQ; q++) begin
      i_q_has_packet[q] = pkts[q].size() > 0;
      i_q_pkt_flits[q]  = (pkts[q].size() > 0) ? LEN_W'(pkts[q][0])
                                               : LEN_W'($urandom_range(MAX_PKT_FLITS, 1));
    end
    v = $urandom_range(99) < p_valid;
    if (stall > 0) begin r = 0; stall--; end
    else r = $urandom_range(99) < p_ready;
    if (m_busy) l = (m_beats == ((early_last >= 0) ? early_last : m_len - 1));
    else        l = 1'($urandom_range(1));
    rv = 0;
    rq = int'($urandom_range(NQ - 1));
    rc = int'($urandom_range(MAX_PKT_FLITS));
    if (ret_once) begin
      rv = 1; rq = ret_q_once; rc = ret_cnt_once; ret_once = 0;
    end else if (ret_rand && $urandom_range(99) < 30) begin
      mx = int'(INIT_CREDITS) - m_cred[rq];
      if (mx > int'(MAX_PKT_FLITS)) mx = MAX_PKT_FLITS;
      rv = 1; rc = int'($urandom_range(mx));
    end
    i_flit_valid     = v;
    i_flit_last      = l;
    i_tx_ready       = r;
    i_cred_ret_valid = rv;
    i_cred_ret_q     = LOG_VC_PRIO'(rq);
    i_cred_ret_cnt   = LEN_W'(rc);
    #1;
    chk("tx_valid", o_tx_valid, m_busy && v && !rst_req);
    chk("flit_ready", o_flit_ready, m_busy && r && !rst_req);
    if (m_busy) chk("tx_last", o_tx_last, l);
    model_step(v, r, l, rv, rq, rc);
    @(posedge ACLK);
    #1;
    chk("sel_valid", o_sel_valid, m_busy);
    chk("sel_q", o_sel_q, m_sel_q);
    for (int q = 0; q < NQ; q++) chk($sformatf("credits%0d", q), o_credits[q], m_cred[q]);
    chk("cred_overflow", o_cred_overflow, m_ovf);
    chk("len_error", o_len_error, m_lerr);
    chk("pkt_sent", o_pkt_sent, m_sent);
    if (o_sel_valid && !prev_sel) dut_log.push_back(int'(o_sel_q));
    prev_sel = o_sel_valid;
  endtask

  task automatic do_reset();
    rst_req = 1;
    repeat (2) cycle();
    rst_req = 0;
    dut_log.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_busy || any_pkts()) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", m_busy || any_pkts(), 0);
  endtask

  initial begin
    int exp_order[11] = '{2, 2, 2, 0, 1, 0, 1, 0, 1, 0, 1};

    // Reset values and a single 5-flit packet on queue 0.
    do_reset();
    chk("rst_credits0", o_credits[0], INIT_CREDITS);
    chk("rst_sel_valid", o_sel_valid, 0);
    chk("rst_pkt_sent", o_pkt_sent, 0);
    pkts[0].push_back(5);
    cycle();
    chk("t1_sel_valid", o_sel_valid, 1);
    chk("t1_sel_q", o_sel_q, 0);
    chk("t1_credits0", o_credits[0], 35);
    repeat (5) cycle();
    chk("t1_pkt_sent", o_pkt_sent, 1);
    chk("t1_sel_low", o_sel_valid, 0);

    // Strict priority then round robin.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pkts[0].push_back(4);
      pkts[1].push_back(4);
    end
    for (int i = 0; i < 3; i++) pkts[2].push_back(4);
    drain(300);
    chk("t2_grants", dut_log.size(), 11);
    for (int i = 0; i < 11; i++)
      if (i < dut_log.size()) chk($sformatf("t2_order%0d", i), dut_log[i], exp_order[i]);

    // Insufficient credits block a grant until a return arrives.
    do_reset();
    pkts[3].push_back(20);
    pkts[3].push_back(17);
    drain(100);
    chk("t3_credits3", o_credits[3], 3);
    pkts[3].push_back(4);
    repeat (3) cycle();
    chk("t3_no_grant", o_sel_valid, 0);
    ret_once = 1; ret_q_once = 3; ret_cnt_once = 1;
    cycle();
    chk("t3_ret_no_grant", o_sel_valid, 0);
    chk("t3_credits4", o_credits[3], 4);
    cycle();
    chk("t3_grant", o_sel_valid, 1);
    chk("t3_credits0", o_credits[3], 0);
    drain(50);

    // Same-cycle grant and return, then clamp on overflow.
    do_reset();
    pkts[1].push_back(20);
    pkts[1].push_back(10);
    drain(100);
    chk("t4_credits10", o_credits[1], 10);
    ret_once = 1; ret_q_once = 1; ret_cnt_once = 4;
    pkts[1].push_back(6);
    cycle();
    chk("t4_grant", o_sel_valid, 1);
    chk("t4_credits8", o_credits[1], 8);
    drain(50);
    pkts[0].push_back(2);
    drain(50);
    chk("t4_credits38", o_credits[0], 38);
    ret_once = 1; ret_q_once = 0; ret_cnt_once = 5;
    cycle();
    chk("t4_clamp", o_credits[0], INIT_CREDITS);
    chk("t4_overflow", o_cred_overflow, 1);
    chk("t4_no_len_err", o_len_error, 0);

    // Early footer: error flagged, packet still ends, no credit adjustment.
    do_reset();
    early_last = 2;
    pkts[0].push_back(5);
    drain(50);
    early_last = -1;
    chk("t5_len_err", o_len_error, 1);
    chk("t5_pkt_sent", o_pkt_sent, 1);
    chk("t5_idle", o_sel_valid, 0);
    chk("t5_credits0", o_credits[0], 35);

    // Link back-pressure mid-packet.
    do_reset();
    pkts[0].push_back(5);
    cycle();
    cycle();
    stall = 3;
    repeat (3) cycle();
    chk("t5_stall_hold", o_sel_valid, 1);
    drain(50);
    chk("t5_stall_sent", o_pkt_sent, 1);
    chk("t5_stall_no_err", o_len_error, 0);

    // Illegal lengths 0 and above the maximum.
    do_reset();
    pkts[2].push_back(0);
    cycle();
    chk("t5_len0_err", o_len_error, 1);
    chk("t5_len0_no_grant", o_sel_valid, 0);
    pkts[2].delete();
    do_reset();
    pkts[1].push_back(25);
    cycle();
    chk("t5_len25_err", o_len_error, 1);
    chk("t5_len25_no_grant", o_sel_valid, 0);
    pkts[1].delete();

    // Reset during the second beat drops the transfer.
    do_reset();
    pkts[0].push_back(5);
    pkts[1].push_back(3);
    cycle();
    cycle();
    rst_req = 1;
    cycle();
    rst_req = 0;
    chk("t6_sel_valid", o_sel_valid, 0);
    chk("t6_sel_q", o_sel_q, 0);
    chk("t6_credits0", o_credits[0], INIT_CREDITS);
    chk("t6_credits1", o_credits[1], INIT_CREDITS);
    chk("t6_pkt_sent", o_pkt_sent, 0);

    // Randomized traffic with throttled valid/ready and credit returns.
    do_reset();
    ret_rand = 1;
    p_valid  = 75;
    p_ready  = 75;
    for (int n = 0; n < 3000; n++) begin
      int q;
      q = int'($urandom_range(NQ - 1));
      if ($urandom_range(3) == 0 && pkts[q].size() < 3)
        pkts[q].push_back(int'($urandom_range(MAX_PKT_FLITS, 1)));
      cycle();
    end
    drain(3000);
    ret_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/exa_crosb_link_credit_arb.md
Name: exa_crosb_link_credit_arb

Overview:
- Downstream neighbour of the per-output s2e VC FIFOs. One instance per crossbar output port, between the s2e queues and the link transmitter.
- Keeps per-VC flit credits for the receiver's input buffers at the far end of the link.
- Picks one VC queue at a time and forwards that whole packet (virtual cut-through). A packet is sent only when its full flit length fits in the downstream credits.

Parameters:
- prio_num, 2, number of priority levels.
- vc_num, 2, VCs per priority. Queue index q = prio*vc_num + vc, so NQ = prio_num*vc_num.
- INIT_CREDITS, 40, flits of downstream buffer per queue. Matches in_fifo_depth.
- MAX_PKT_FLITS, 20, largest legal packet, header and footer included.
- CRED_W, log2(INIT_CREDITS+1), width of a credit counter.
- LEN_W, log2(MAX_PKT_FLITS+1), width of a packet length.
- logVcPrio, log2(NQ), width of a queue index.

Ports:
- ACLK, in, 1, clock.
- ARESET, in, 1, reset, synchronous, active-high.
- i_q_has_packet, in, NQ, head packet present per queue.
- i_q_pkt_flits, in, NQ x LEN_W, flit length of each queue's head packet.
- o_sel_q, out, logVcPrio, granted queue. Drives the s2e read mux and the output VC field.
- o_sel_valid, out, 1, a packet transfer is in progress.
- i_flit_valid, in, 1, flit valid from the selected queue.
- i_flit_last, in, 1, footer flit.
- o_flit_ready, out, 1, pop the selected queue.
- o_tx_valid, out, 1, flit valid to the link.
- o_tx_last, out, 1, footer flag to the link.
- i_tx_ready, in, 1, link accepts a flit.
- i_cred_ret_valid, in, 1, credit return strobe.
- i_cred_ret_q, in, logVcPrio, queue whose credits are returned.
- i_cred_ret_cnt, in, LEN_W, number of flits returned.
- o_credits, out, NQ x CRED_W, current credit count per queue.
- o_cred_overflow, out, 1, sticky error.
- o_len_error, out, 1, sticky error.
- o_pkt_sent, out, 32, packets sent. Wraps.

Behaviour:
- Reset state: o_credits = INIT_CREDITS on every queue; o_sel_q = 0; o_sel_valid = 0; o_cred_overflow = 0; o_len_error = 0; o_pkt_sent = 0; FSM in IDLE; all round-robin pointers = 0.
- A reset that arrives mid-packet drops the transfer; no flit handshake occurs in the reset cycle.
- Eligibility: queue q is eligible when i_q_has_packet[q] = 1 and credits[q] >= i_q_pkt_flits[q].
- A length of 0, or a length above MAX_PKT_FLITS, makes the queue ineligible and sets o_len_error.
- Arbitration order:
  - Strict priority: the highest prio with any eligible queue wins.
  - Within that prio, round robin over its vc_num queues.
  - Each prio has its own pointer, which advances to winner+1 (mod vc_num) on grant.
- FSM IDLE:
  - With at least one eligible queue at edge t, register the grant.
  - From t+1: o_sel_q = winner, o_sel_valid = 1, credits[winner] -= length, FSM moves to XFER.
  - Grant latency is one cycle.
- FSM XFER:
  - o_tx_valid = i_flit_valid and o_tx_last = i_flit_last, both combinational.
  - o_flit_ready = i_tx_ready.
  - A beat is i_flit_valid & i_tx_ready; each beat increments the flit counter.
  - On a beat with i_flit_last: o_pkt_sent increments and the FSM returns to IDLE. o_sel_valid = 0 on the next cycle, which leaves one bubble cycle between packets.
  - If last arrives with counter+1 != granted length, set o_len_error, end the packet normally, and do not adjust credits.
- FSM IDLE outputs: o_tx_valid = 0 and o_flit_ready = 0.
- Credit return: credits[i_cred_ret_q] += i_cred_ret_cnt.
  - A return and a grant on the same queue in the same cycle: new = old - length + ret, computed in CRED_W+1 bits.
  - If the result exceeds INIT_CREDITS, clamp to INIT_CREDITS and set o_cred_overflow.
- Sticky error flags clear only on reset.

Decomposition:
- Add to exanet_crosb_pkg:
  - typedef enum {IDLE, XFER} link_arb_state_t.
  - function credit_fits(credits, length).
- Sub-module exa_crosb_prio_rr_arb: combinational strict-priority plus per-prio round-robin pick, returning winner index and found flag. Pointers are held in the parent and passed in.

Test Plan:
- Reset, then queue 0 has a 5-flit packet and i_tx_ready = 1 → o_sel_valid rises 1 cycle later with o_sel_q = 0; credits[0] = 35; 5 beats; o_pkt_sent = 1; o_sel_valid low the cycle after the last beat.
- Queues 0,1 (prio 0) and 2 (prio 1) each have 4-flit packets continuously → grant order 2,2,2… while queue 2 stays eligible. With queue 2 empty, order 0,1,0,1.
- credits[3] = 3 and queue 3 head length 4 → no grant. i_cred_ret_q = 3 with cnt = 1 → grant on the following edge and credits[3] = 0.
- Same-cycle grant on queue 1 (length 6, credits 10) and return of 4 on queue 1 → credits[1] = 8. A return of 5 at credits 38 → credits clamped to 40 and o_cred_overflow = 1.
- Granted length 5 but i_flit_last on the 3rd beat → o_len_error = 1, FSM back in IDLE, o_pkt_sent incremented. With i_tx_ready held 0 for 3 cycles mid-packet → no beats count and o_flit_ready = 0.
- Assert ARESET during XFER beat 2 → the next cycle shows all reset values, including credits = 40, and no spurious grant in the reset cycle.
